// File: rtl/unpack_rq0_ctrl.sv
// Sequencer for unpack_rq0: fetches packed h words over req/gnt and steps the datapath once per word.
// First dp_en comes two cycles after the first grant; pk_gnt gaps stall dp_en without dropping data.
module unpack_rq0_ctrl #(
    parameter int N_PAIRS   = 350,
    parameter int ADDR_W    = 9,
    parameter int BASE_ADDR = 0,
    parameter int COEF_W    = 13,
    parameter int TIMEOUT   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  pk_req,
    output logic [ADDR_W-1:0]     pk_addr,
    input  logic                  pk_gnt,
    input  logic [2*COEF_W-1:0]   pk_rdata,
    output logic                  dp_rst,
    output logic                  dp_en,
    output logic [COEF_W-1:0]     dp_even,
    output logic [COEF_W-1:0]     dp_odd,
    input  logic                  odd_done,
    input  logic                  even_done
);
    localparam int CNT_W = $clog2(N_PAIRS + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + N_PAIRS - 1);
    localparam logic [CNT_W-1:0]  PAIRS      = CNT_W'(N_PAIRS);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_STREAM,
        S_FINAL,
        S_DONE
    } state_t;

    state_t              state_q;
    logic                err_q;
    logic                pend_q;
    logic                rd_ptr_q;
    logic                wr_ptr_q;
    logic                fin_en_q;
    logic [1:0]          occ_q;
    logic [1:0]          occ_d;
    logic [CNT_W-1:0]    issued_q;
    logic [CNT_W-1:0]    step_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [2*COEF_W-1:0] fifo_q [2];

    logic                stream;
    logic                pop;
    logic                grant;
    logic                flag_err;
    logic [1:0]          occ_after_pop;
    logic [2*COEF_W-1:0] head;

    always_comb begin
        stream        = (state_q == S_STREAM);
        pop           = stream && (occ_q != 2'd0);
        // A pop in this cycle frees its slot for a new request, keeping one pair per cycle.
        occ_after_pop = occ_q - {1'b0, pop};
        pk_req        = stream && (issued_q < PAIRS) && ((occ_after_pop + {1'b0, pend_q}) < 2'd2);
        grant         = pk_req && pk_gnt;
        occ_d         = occ_after_pop + {1'b0, pend_q};
        head          = fifo_q[rd_ptr_q];
        dp_en         = pop || ((state_q == S_FINAL) && fin_en_q);
        dp_even       = pop ? head[COEF_W-1:0] : '0;
        dp_odd        = pop ? head[2*COEF_W-1:COEF_W] : '0;
        flag_err      = stream && (step_q < PAIRS) && (odd_done || even_done);
        busy          = (state_q != S_IDLE) && (state_q != S_DONE);
        done          = (state_q == S_DONE);
        error         = err_q;
        dp_rst        = (state_q == S_IDLE) || (state_q == S_INIT);
        pk_addr       = addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            err_q     <= 1'b0;
            pend_q    <= 1'b0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            fin_en_q  <= 1'b0;
            occ_q     <= 2'd0;
            issued_q  <= '0;
            step_q    <= '0;
            addr_q    <= FIRST_ADDR;
            tmo_q     <= '0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            if (pend_q) begin
                fifo_q[wr_ptr_q] <= pk_rdata;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                step_q   <= step_q + 1'b1;
            end
            occ_q  <= occ_d;
            pend_q <= grant;
            if (grant) begin
                issued_q <= issued_q + 1'b1;
                if (addr_q != LAST_ADDR) begin
                    addr_q <= addr_q + 1'b1;
                end
            end
            if (flag_err) begin
                err_q <= 1'b1;
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_INIT;
                        err_q   <= 1'b0;
                    end
                end
                S_INIT: begin
                    pend_q   <= 1'b0;
                    rd_ptr_q <= 1'b0;
                    wr_ptr_q <= 1'b0;
                    occ_q    <= 2'd0;
                    issued_q <= '0;
                    step_q   <= '0;
                    addr_q   <= FIRST_ADDR;
                    tmo_q    <= '0;
                    fin_en_q <= 1'b0;
                    state_q  <= S_STREAM;
                end
                S_STREAM: begin
                    if (pop && (step_q == PAIRS - 1'b1)) begin
                        state_q  <= S_FINAL;
                        fin_en_q <= 1'b1;
                        tmo_q    <= '0;
                    end
                end
                S_FINAL: begin
                    // The timeout window starts with the extra enable cycle itself.
                    fin_en_q <= 1'b0;
                    if (fin_en_q && !odd_done) begin
                        err_q <= 1'b1;
                    end
                    if (!fin_en_q && even_done) begin
                        state_q <= S_DONE;
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_unpack_rq0_ctrl.sv
// Bench for unpack_rq0_ctrl: randomized grant memory plus a step-counting datapath model.
module tb_unpack_rq0_ctrl;
    localparam int NP = 350;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error, pk_req, pk_gnt, dp_rst, dp_en;
    logic        odd_done, even_done;
    logic [8:0]  pk_addr;
    logic [25:0] pk_rdata;
    logic [12:0] dp_even, dp_odd;

    unpack_rq0_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
        .pk_req(pk_req), .pk_addr(pk_addr), .pk_gnt(pk_gnt), .pk_rdata(pk_rdata),
        .dp_rst(dp_rst), .dp_en(dp_en), .dp_even(dp_even), .dp_odd(dp_odd),
        .odd_done(odd_done), .even_done(even_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pct;
        int fstep;
        bit hold;
        int exp_err;
        int exp_lag;
    } vec_t;
    vec_t tbl [6];

    int total = 0, bad = 0;
    int gnt_pct = 100, force_step = -1;
    bit hold_even = 1'b0;
    int clr_req = 0, clr_seen = 0;

    int cyc = 0, dp_cnt = 0, pulses = 0, first_pulse = -1, fin_cyc = -1, done_cyc = -1;
    int rst_cyc = 0, n_grants = 0, addr_bad = 0, pair_bad = 0;
    bit last_grant = 1'b0;
    logic [8:0] last_addr = '0;

    // Memory word k holds odd = k, even = k + 1 (13-bit wrap).
    function automatic logic [25:0] word(input int k);
        logic [12:0] kk;
        kk = k[12:0];
        return {kk, kk + 13'd1};
    endfunction

    always @(negedge clk) begin
        logic [25:0] w;
        bit g;
        cyc++;
        pk_rdata  = last_grant ? word(int'(last_addr)) : 26'($urandom);
        odd_done  = (dp_cnt >= NP) || (force_step >= 0 && dp_cnt == force_step);
        even_done = !hold_even && (dp_cnt > NP);
        if (dp_rst) dp_cnt = 0;
        else if (dp_en) dp_cnt++;
        if (dp_en && !dp_rst) begin
            if (pulses < NP) w = word(pulses);
            else w = '0;
            if (pulses > NP || dp_even !== w[12:0] || dp_odd !== w[25:13]) pair_bad++;
            if (pulses == 0) first_pulse = cyc;
            pulses++;
            if (pulses == NP + 1) fin_cyc = cyc;
        end
        if (dp_rst) rst_cyc++;
        if (done && done_cyc < 0) done_cyc = cyc;
        g          = ($urandom_range(99) < gnt_pct);
        pk_gnt     = g;
        last_grant = pk_req && g;
        last_addr  = pk_addr;
        if (last_grant) begin
            if (pk_addr !== 9'(n_grants)) addr_bad++;
            n_grants++;
        end
        if (clr_req != clr_seen) begin
            pulses = 0; first_pulse = -1; fin_cyc = -1; done_cyc = -1;
            rst_cyc = 0; n_grants = 0; addr_bad = 0; pair_bad = 0;
            clr_seen = clr_req;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, int'({busy, done, error, pk_req, dp_en, dp_rst}), 1);
        chk({tag, "_addr"}, int'(pk_addr), 0);
        chk({tag, "_data"}, int'({dp_even, dp_odd}), 0);
    endtask

    task automatic do_run(input int pct, input int fstep, input bit hold);
        gnt_pct = pct; force_step = fstep; hold_even = hold;
        clr_req++;
        @(negedge clk); #1;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        chk("err_clear_on_start", int'(error), 0);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_within_budget", int'(ok), 1);
    endtask

    task automatic wait_pulses(input int target);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); #1;
            if (pulses >= target) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach_step", int'(ok), 1);
    endtask

    task automatic run_checks(input int exp_err, input int exp_lag, input bit contiguous);
        chk("dp_en_pulses", pulses, NP + 1);
        chk("grants", n_grants, NP);
        chk("addr_seq_errs", addr_bad, 0);
        chk("pair_errs", pair_bad, 0);
        chk("error", int'(error), exp_err);
        chk("busy_in_done", int'(busy), 0);
        chk("done_lag", done_cyc - fin_cyc, exp_lag);
        chk("dp_rst_cycles", rst_cyc, 1);
        if (contiguous) chk("dp_en_span", fin_cyc - first_pulse, NP);
    endtask

    initial begin
        bit ok;
        tbl[0] = '{100, -1,  1'b0, 0, 2};
        tbl[1] = '{40,  -1,  1'b0, 0, 2};
        tbl[2] = '{70,  100, 1'b0, 1, 2};
        tbl[3] = '{100, -1,  1'b0, 0, 2};
        tbl[4] = '{100, -1,  1'b1, 1, 8};
        tbl[5] = '{55,  -1,  1'b1, 1, 8};

        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("idle_dp_rst", int'({busy, done, dp_rst}), 1);

        for (int i = 0; i < 6; i++) begin
            do_run(tbl[i].pct, tbl[i].fstep, tbl[i].hold);
            wait_done(ok);
            run_checks(tbl[i].exp_err, tbl[i].exp_lag, tbl[i].pct == 100);
        end

        // Start pulsed mid-stream is ignored; this run also starts from DONE.
        do_run(60, -1, 1'b0);
        wait_pulses(50);
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done(ok);
        run_checks(0, 2, 1'b0);

        // Reset in the middle of streaming, then a clean rerun from address 0.
        do_run(100, -1, 1'b0);
        wait_pulses(200);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("midreset");
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("idle_after_reset", int'({busy, done, error}), 0);
        do_run(100, -1, 1'b0);
        wait_done(ok);
        run_checks(0, 2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
